// File: rtl/seq_muldiv_if.sv
// Request/response bundle for seq_muldiv: operands, funct code and start in,
// busy/done status and HI/LO readback out.
// master drives the request side, slave is the arithmetic unit.
interface seq_muldiv_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] dataA;
    logic [WIDTH-1:0] dataB;
    logic [5:0]       Signal;
    logic             start;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Output;

    modport master (output dataA, dataB, Signal, start,
                    input  busy, done, Output);
    modport slave  (input  dataA, dataB, Signal, start,
                    output busy, done, Output);
endinterface

// File: rtl/seq_muldiv.sv
// Sequential MIPS-style multiply/divide unit writing HI/LO; optional divider
// enabled by macro SEQ_MULDIV_DIV_EN (restoring, same latency as multiply).
// Latency WIDTH+1 busy cycles then a done pulse; starts while busy are dropped.
module seq_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic        clk,
    input  logic        reset,
    seq_muldiv_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    localparam logic [5:0] F_MFHI  = 6'd16;
    localparam logic [5:0] F_MFLO  = 6'd18;
    localparam logic [5:0] F_MULT  = 6'd24;
    localparam logic [5:0] F_MULTU = 6'd25;
`ifdef SEQ_MULDIV_DIV_EN
    localparam logic [5:0] F_DIV   = 6'd26;
    localparam logic [5:0] F_DIVU  = 6'd27;
`endif

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    // mcand: |B|; p_hi/p_lo: product halves (or remainder / dividend-quotient)
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] p_hi;
    logic [WIDTH-1:0] p_lo;
    logic             neg_p;

    logic             op_ok;
    logic             signed_op;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic             accept;
    logic [WIDTH:0]   add_sum;
    logic [2*WIDTH-1:0] prod_mag;
    logic [2*WIDTH-1:0] prod_fix;

`ifdef SEQ_MULDIV_DIV_EN
    logic             op_div;
    logic             neg_r;
    logic             is_div;
    logic [WIDTH:0]   shifted;
    logic             ge;
    logic [WIDTH-1:0] sub;

    assign is_div    = (bus.Signal == F_DIV) || (bus.Signal == F_DIVU);
    assign op_ok     = (bus.Signal == F_MULT) || (bus.Signal == F_MULTU) || is_div;
    assign signed_op = (bus.Signal == F_MULT) || (bus.Signal == F_DIV);
    // One restoring step: shift next dividend bit in, subtract divisor if it fits.
    assign shifted   = {p_hi, p_lo[WIDTH-1]};
    assign ge        = shifted >= {1'b0, mcand};
    assign sub       = WIDTH'(shifted - {1'b0, mcand});
`else
    assign op_ok     = (bus.Signal == F_MULT) || (bus.Signal == F_MULTU);
    assign signed_op = (bus.Signal == F_MULT);
`endif

    // Signed forms run on magnitudes; the most-negative value is its own magnitude.
    assign abs_a  = (signed_op && bus.dataA[WIDTH-1]) ? (~bus.dataA + 1'b1) : bus.dataA;
    assign abs_b  = (signed_op && bus.dataB[WIDTH-1]) ? (~bus.dataB + 1'b1) : bus.dataB;
    assign accept = (state == IDLE) && bus.start && op_ok;

    // Shift-add: add multiplicand into the upper half when the current multiplier bit is set.
    assign add_sum  = {1'b0, p_hi} + (p_lo[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
    assign prod_mag = {p_hi, p_lo};
    assign prod_fix = neg_p ? (~prod_mag + 1'b1) : prod_mag;

    // Control FSM and datapath registers; reset aborts any in-flight operation.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            mcand  <= '0;
            p_hi   <= '0;
            p_lo   <= '0;
            neg_p  <= 1'b0;
`ifdef SEQ_MULDIV_DIV_EN
            op_div <= 1'b0;
            neg_r  <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        mcand  <= abs_b;
                        p_hi   <= '0;
                        p_lo   <= abs_a;
                        neg_p  <= signed_op && (bus.dataA[WIDTH-1] ^ bus.dataB[WIDTH-1]);
                        cnt    <= '0;
                        busy_q <= 1'b1;
                        state  <= RUN;
`ifdef SEQ_MULDIV_DIV_EN
                        op_div <= is_div;
                        neg_r  <= signed_op && bus.dataA[WIDTH-1];
`endif
                    end
                end
                RUN: begin
`ifdef SEQ_MULDIV_DIV_EN
                    if (op_div) begin
                        p_hi <= ge ? sub : shifted[WIDTH-1:0];
                        p_lo <= {p_lo[WIDTH-2:0], ge};
                    end else begin
                        p_hi <= add_sum[WIDTH:1];
                        p_lo <= {add_sum[0], p_lo[WIDTH-1:1]};
                    end
`else
                    p_hi <= add_sum[WIDTH:1];
                    p_lo <= {add_sum[0], p_lo[WIDTH-1:1]};
`endif
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH-1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
`ifdef SEQ_MULDIV_DIV_EN
                    if (op_div) begin
                        // Zero divisor leaves all-ones quotient; skip its sign fix.
                        lo <= (neg_p && (mcand != '0)) ? (~p_lo + 1'b1) : p_lo;
                        hi <= neg_r ? (~p_hi + 1'b1) : p_hi;
                    end else begin
                        hi <= prod_fix[2*WIDTH-1:WIDTH];
                        lo <= prod_fix[WIDTH-1:0];
                    end
`else
                    hi <= prod_fix[2*WIDTH-1:WIDTH];
                    lo <= prod_fix[WIDTH-1:0];
`endif
                    cnt    <= '0;
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;

    // Readback mux follows the live funct code.
    always_comb begin
        bus.Output = '0;
        if (bus.Signal == F_MFHI) begin
            bus.Output = hi;
        end else if (bus.Signal == F_MFLO) begin
            bus.Output = lo;
        end
    end
endmodule

// File: tb/tb_seq_muldiv.sv
// Directed + randomized bench for seq_muldiv at WIDTH=32 with a longint reference model.
module tb_seq_muldiv;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;

    seq_muldiv_if #(.WIDTH(32)) bus ();

    seq_muldiv #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: {HI, LO} from plain integer arithmetic.
    function automatic logic [63:0] model(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        logic [63:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r = '0;
        case (op)
            6'd24: r = 64'(sa * sb);
            6'd25: r = {32'd0, a} * {32'd0, b};
            6'd26: if (b == 32'd0) r = {a, 32'hFFFFFFFF};
                   else r = {32'(sa % sb), 32'(sa / sb)};
            6'd27: if (b == 32'd0) r = {a, 32'hFFFFFFFF};
                   else r = {a % b, a / b};
            default: r = '0;
        endcase
        return r;
    endfunction

    // Present a request for one cycle; returns at the negedge of cycle 1.
    task automatic launch(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.Signal = op;
        bus.dataA  = a;
        bus.dataB  = b;
        bus.start  = 1'b1;
        @(negedge clk);
        bus.start  = 1'b0;
    endtask

    // Cycles from the start cycle until done, bounded; also counts busy cycles.
    task automatic wait_done(output int lat, output int bcnt);
        lat  = 1;
        bcnt = 0;
        while (bus.done !== 1'b1 && lat < 200) begin
            if (bus.busy === 1'b1) bcnt++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic read_hilo(input string tag, input logic [31:0] ehi, input logic [31:0] elo);
        bus.Signal = 6'd16;
        #1 chk({tag, "_hi"}, 64'(bus.Output), 64'(ehi));
        bus.Signal = 6'd18;
        #1 chk({tag, "_lo"}, 64'(bus.Output), 64'(elo));
    endtask

    task automatic run_op(input string tag, input logic [5:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
        int lat;
        int bc;
        launch(op, a, b);
        wait_done(lat, bc);
        chk({tag, "_lat"}, 64'(lat), 64'd34);
        chk({tag, "_busycnt"}, 64'(bc), 64'd33);
        chk({tag, "_busy_at_done"}, 64'(bus.busy), 64'd0);
        @(negedge clk);
        chk({tag, "_done_drop"}, 64'(bus.done), 64'd0);
        read_hilo(tag, ehi, elo);
    endtask

    task automatic count_done(input int n, output int pulses);
        pulses = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) pulses++;
        end
    endtask

    initial begin
        int lat;
        int bc;
        int pulses;
        logic [63:0] m;
        logic [5:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] ehi;
        logic [31:0] elo;

        reset      = 1'b0;
        bus.dataA  = '0;
        bus.dataB  = '0;
        bus.Signal = '0;
        bus.start  = 1'b0;
        #2 reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        read_hilo("rst", 32'd0, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        run_op("multu_max", 6'd25, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
        run_op("mult_neg",  6'd24, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB);
        run_op("mult_min",  6'd24, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);

        // Start while busy with a changed opcode and operands must be ignored.
        @(negedge clk);
        launch(6'd25, 32'd6, 32'd7);
        lat = 1;
        while (bus.done !== 1'b1 && lat < 200) begin
            if (lat == 10) begin
                bus.start = 1'b1; bus.Signal = 6'd24; bus.dataA = 32'hDEADBEEF;
            end else if (lat == 11) begin
                bus.start = 1'b0; bus.dataA = 32'h12345678;
            end
            @(negedge clk);
            lat++;
        end
        chk("busy_start_lat", 64'(lat), 64'd34);
        count_done(40, pulses);
        chk("busy_start_extra_done", 64'(pulses), 64'd0);
        read_hilo("busy_start", 32'd0, 32'd42);

        // Reset mid-operation aborts asynchronously and clears HI/LO.
        launch(6'd25, 32'd5, 32'd9);
        repeat (14) @(negedge clk);
        #2 reset = 1'b1;
        #1 chk("abort_busy", 64'(bus.busy), 64'd0);
        chk("abort_done", 64'(bus.done), 64'd0);
        bus.Signal = 6'd18;
        #1 chk("abort_mflo", 64'(bus.Output), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        count_done(40, pulses);
        chk("abort_no_done", 64'(pulses), 64'd0);
        read_hilo("abort_after", 32'd0, 32'd0);

        // Non-operation codes are ignored.
        @(negedge clk);
        launch(6'd16, 32'd3, 32'd3);
        chk("ign_mfhi_busy", 64'(bus.busy), 64'd0);
        count_done(5, pulses);
        chk("ign_mfhi_done", 64'(pulses), 64'd0);

`ifdef SEQ_MULDIV_DIV_EN
        run_op("div_neg",  6'd26, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("divu_zero", 6'd27, 32'd100, 32'd0, 32'd100, 32'hFFFFFFFF);
`else
        launch(6'd27, 32'd100, 32'd3);
        chk("divu_off_busy", 64'(bus.busy), 64'd0);
        count_done(40, pulses);
        chk("divu_off_done", 64'(pulses), 64'd0);
        read_hilo("divu_off", 32'd0, 32'd0);
`endif

        // Back-to-back: second start issued in the done cycle of the first.
        @(negedge clk);
        launch(6'd25, 32'd2, 32'd3);
        wait_done(lat, bc);
        chk("b2b_first_lat", 64'(lat), 64'd34);
        bus.Signal = 6'd18;
        #1 chk("b2b_first_lo", 64'(bus.Output), 64'd6);
        launch(6'd25, 32'd4, 32'd5);
        wait_done(lat, bc);
        chk("b2b_second_lat", 64'(lat), 64'd34);
        @(negedge clk);
        read_hilo("b2b_second", 32'd0, 32'd20);

        // Randomized operations against the reference model.
        for (int i = 0; i < 24; i++) begin
`ifdef SEQ_MULDIV_DIV_EN
            op = 6'(24 + $urandom_range(0, 3));
`else
            op = 6'(24 + $urandom_range(0, 1));
`endif
            case ($urandom_range(0, 5))
                0: a = 32'h80000000;
                1: a = 32'hFFFFFFFF;
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 6))
                0: b = 32'h80000000;
                1: b = 32'd0;
                2: b = 32'd1;
                default: b = $urandom;
            endcase
            m   = model(op, a, b);
            ehi = m[63:32];
            elo = m[31:0];
            @(negedge clk);
            run_op($sformatf("rnd%0d_op%0d", i, op), op, a, b, ehi, elo);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/seq_muldiv.md
SEQ_MULDIV -- requirements
Module: seq_muldiv

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and HI/LO register width; legal values are 8..64 and even.
REQ-002 Port clk SHALL be an input, 1 bit wide: the single clock; all state changes on its rising edge.
REQ-003 Port reset SHALL be an input, 1 bit wide, asynchronous and active-high.
REQ-004 Port dataA SHALL be an input, WIDTH bits wide: multiplicand / dividend.
REQ-005 Port dataB SHALL be an input, WIDTH bits wide: multiplier / divisor.
REQ-006 Port Signal SHALL be an input, 6 bits wide: funct code. 24=MULT, 25=MULTU, 26=DIV, 27=DIVU, 16=MFHI, 18=MFLO.
REQ-007 Port start SHALL be an input, 1 bit wide: one-cycle request to launch the operation in Signal.
REQ-008 Port busy SHALL be an output, 1 bit wide: operation in progress.
REQ-009 Port done SHALL be an output, 1 bit wide: one-cycle completion pulse.
REQ-010 Port Output SHALL be an output, WIDTH bits wide: HI or LO readback.

Function
REQ-011 FSM states SHALL be IDLE, RUN and FIX: IDLE->RUN on an accepted start; RUN->FIX after WIDTH iterations; FIX->IDLE unconditionally.
REQ-012 Start SHALL be accepted only in IDLE with Signal in {24,25} (or {26,27} per REQ-023); other codes and start while busy SHALL be ignored with no state change.
REQ-013 dataA, dataB and Signal SHALL be latched at the accepting edge; later input changes SHALL NOT affect the operation.
REQ-014 busy SHALL be 1 from the edge after acceptance for exactly WIDTH+1 cycles (WIDTH RUN cycles + 1 FIX), giving 33 cycles at WIDTH=32.
REQ-015 Multiply SHALL use shift-add, one multiplier bit per RUN cycle, on a 2*WIDTH-bit product; unsigned forms operate on raw operands.
REQ-016 Signed forms SHALL operate on magnitudes in RUN and apply the sign correction in FIX (product sign = signA XOR signB).
REQ-017 In FIX, HI SHALL receive the upper WIDTH bits and LO the lower WIDTH bits; HI/LO SHALL change at no other time.
REQ-018 done SHALL pulse high for one cycle, coincident with the first cycle HI/LO hold the new result and busy is 0.
REQ-019 Output SHALL be combinational: HI when Signal=16, LO when Signal=18, else 0; it is valid during busy and then shows the previous result.
REQ-020 A start presented in the done cycle SHALL be accepted (back-to-back operation).
REQ-021 The most-negative operand (e.g. 0x80000000) in MULT SHALL produce the exact 2*WIDTH-bit signed product.

Reset
REQ-022 Reset SHALL force state=IDLE, busy=0, done=0, HI=0, LO=0 and iteration counter=0 immediately; an in-flight operation SHALL be aborted with no result written.

Configuration
REQ-023 Macro SEQ_MULDIV_DIV_EN: when defined, DIV/DIVU SHALL use restoring division (one quotient bit per RUN cycle, same latency as multiply), LO=quotient, HI=remainder; signed quotient truncates toward zero and the remainder takes the dividend's sign; divide by zero SHALL give LO=all-ones, HI=dividend. When undefined, codes 26/27 SHALL be ignored as in REQ-012 and no divider logic is present.

Verification
REQ-024 MULTU, WIDTH=32, A=0xFFFFFFFF, B=0xFFFFFFFF, start at cycle 0 -> busy cycles 1..33, done at cycle 34, then MFHI=0xFFFFFFFE and MFLO=0x00000001.
REQ-025 MULT, A=-3, B=7 -> MFHI=0xFFFFFFFF, MFLO=0xFFFFFFEB (-21); MULT A=0x80000000, B=0x80000000 -> HI=0x40000000, LO=0.
REQ-026 Start MULTU 6*7, then reassert start with a MULT at cycle 10 while busy, and toggle dataA -> second start ignored; result HI=0, LO=42; done pulses once.
REQ-027 Reset asserted at cycle 15 of a MULTU after a prior result of 42 -> busy=0 and done=0 asynchronously, MFLO=0, no done pulse follows.
REQ-028 With SEQ_MULDIV_DIV_EN: DIV -7/2 -> LO=-3, HI=-1; DIVU 100/0 -> LO=0xFFFFFFFF, HI=100; without the macro, DIVU start -> busy stays 0.
REQ-029 Back-to-back: MULTU 2*3, then MULTU 4*5 started in the done cycle -> second done exactly 34 cycles later, LO=20.
